sinc_share_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer that time-shares one external SINC (signed +1) unit among
//  NUM_REQ requesters. Latches the winner's operand into the SINC input register, then

---
 rtl/sinc_share_arbiter.sv | 142 ++++++++++++++
 tb/tb_sinc_share_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sinc_share_arbiter.sv
// sinc_share_arbiter
//   Time-shares one external combinational SINC (signed a+1) unit among NUM_REQ
//   requesters. A round-robin pick in IDLE latches the winner's operand into the
//   SINC input register (sinc_a). The following edge captures the SINC output
//   as result and reports it with the owner's index. One op every two cycles.
//
// Ports
//   Clk      rising-edge clock
//   Rst      synchronous active-high reset
//   req      per-requester request; held until its grant pulse is seen
//   op_a     packed operands, requester i at [i*DATAWIDTH +: DATAWIDTH]
//   grant    registered one-hot pulse: operand of that requester accepted
//   sinc_a   registered operand driving the shared SINC input
//   sinc_d   shared SINC output (combinational sinc_a + 1)
//   result   registered result, held until the next done
//   done     one-cycle pulse: result / done_id / ovf are valid
//   done_id  index of the requester that owns result
//   ovf      signed overflow (operand was the most positive value)

module sinc_share_arbiter #(
    parameter  int DATAWIDTH = 32,
    parameter  int NUM_REQ   = 4,
    localparam int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           Clk,
    input  logic                           Rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*DATAWIDTH-1:0]   op_a,
    output logic [NUM_REQ-1:0]             grant,
    output logic [DATAWIDTH-1:0]           sinc_a,
    input  logic [DATAWIDTH-1:0]           sinc_d,
    output logic [DATAWIDTH-1:0]           result,
    output logic                           done,
    output logic [IDW-1:0]                 done_id,
    output logic                           ovf
);

    // Most positive signed value; +1 on it wraps to the most negative.
    localparam logic [DATAWIDTH-1:0] SMAX = {1'b0, {(DATAWIDTH-1){1'b1}}};
    localparam logic [IDW-1:0]       LAST = IDW'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                          state, state_nxt;
    logic [IDW-1:0]                  last_win, last_win_nxt;
    logic [IDW-1:0]                  cur_id, cur_id_nxt;
    logic [NUM_REQ-1:0]              grant_nxt;
    logic [DATAWIDTH-1:0]            sinc_a_nxt;
    logic [DATAWIDTH-1:0]            result_nxt;
    logic                            done_nxt;
    logic [IDW-1:0]                  done_id_nxt;
    logic                            ovf_nxt;

    // Per-requester operand view of the flat bus.
    logic [NUM_REQ-1:0][DATAWIDTH-1:0] op_v;
    assign op_v = op_a;

    // Round-robin pick: scan last_win+1, last_win+2, ... (mod NUM_REQ) and take
    // the first active request. last_win itself is visited last, so a requester
    // that keeps req high after its grant drops to lowest priority.
    logic                            win_vld;
    logic [IDW-1:0]                  win_id;
    logic [IDW-1:0]                  cand;

    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDW'((int'(last_win) + k) % NUM_REQ);
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_id  = cand;
            end
        end
    end

    // Next-state and next-output logic. grant/done are pulses, everything else
    // holds unless this state updates it.
    always_comb begin
        state_nxt    = state;
        last_win_nxt = last_win;
        cur_id_nxt   = cur_id;
        grant_nxt    = '0;
        sinc_a_nxt   = sinc_a;
        result_nxt   = result;
        done_nxt     = 1'b0;
        done_id_nxt  = done_id;
        ovf_nxt      = ovf;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    grant_nxt[win_id] = 1'b1;
                    sinc_a_nxt        = op_v[win_id];
                    cur_id_nxt        = win_id;
                    state_nxt         = BUSY;
                end
            end
            BUSY: begin
                // sinc_d is a+1 of the operand registered last edge; no
                // arbitration here, so req/op_a are ignored this cycle.
                result_nxt   = sinc_d;
                ovf_nxt      = (sinc_a == SMAX);
                done_nxt     = 1'b1;
                done_id_nxt  = cur_id;
                last_win_nxt = cur_id;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A reset in BUSY simply discards the in-flight op: last_win is not
    // advanced and no done is produced.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= IDLE;
            last_win <= LAST;
            cur_id   <= '0;
            grant    <= '0;
            sinc_a   <= '0;
            result   <= '0;
            done     <= 1'b0;
            done_id  <= '0;
            ovf      <= 1'b0;
        end else begin
            state    <= state_nxt;
            last_win <= last_win_nxt;
            cur_id   <= cur_id_nxt;
            grant    <= grant_nxt;
            sinc_a   <= sinc_a_nxt;
            result   <= result_nxt;
            done     <= done_nxt;
            done_id  <= done_id_nxt;
            ovf      <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_sinc_share_arbiter.sv
// tb_sinc_share_arbiter
//   Drives sinc_share_arbiter with a behavioural SINC (a+1). Each accepted
//   grant pushes its expected {id, result, ovf} to a scoreboard queue; a
//   monitor pops and compares on every done pulse.

module tb_sinc_share_arbiter;

    localparam int W = 32;
    localparam int N = 4;

    logic            Clk = 1'b0;
    logic            Rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*W-1:0]  op_a;
    logic [N-1:0]    grant;
    logic [W-1:0]    sinc_a;
    logic [W-1:0]    sinc_d;
    logic [W-1:0]    result;
    logic            done;
    logic [1:0]      done_id;
    logic            ovf;

    logic [W-1:0]    op_arr [N];

    assign op_a   = {op_arr[3], op_arr[2], op_arr[1], op_arr[0]};
    assign sinc_d = sinc_a + 32'd1;

    sinc_share_arbiter #(.DATAWIDTH(W), .NUM_REQ(N)) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .req     (req),
        .op_a    (op_a),
        .grant   (grant),
        .sinc_a  (sinc_a),
        .sinc_d  (sinc_d),
        .result  (result),
        .done    (done),
        .done_id (done_id),
        .ovf     (ovf)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] res;
        logic        ovf;
    } exp_t;

    exp_t sb[$];

    // done must follow a grant by exactly one edge unless Rst hit that edge.
    logic grant_d = 1'b0;

    always @(posedge Clk) begin
        exp_t e;
        logic exp_done;
        #1;
        exp_done = grant_d && !Rst;
        if (done || exp_done)
            chk("done_pulse", 32'(done), 32'(exp_done));
        if (done) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("done_id", 32'(done_id), 32'(e.id));
                chk("ovf", 32'(ovf), 32'(e.ovf));
            end
            chk("grant_done_excl", 32'(|grant), 32'd0);
        end
        grant_d = |grant;
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_grant"},   32'(grant),   32'd0);
        chk({tag, "_done"},    32'(done),    32'd0);
        chk({tag, "_result"},  result,       32'd0);
        chk({tag, "_sinc_a"},  sinc_a,       32'd0);
        chk({tag, "_done_id"}, 32'(done_id), 32'd0);
        chk({tag, "_ovf"},     32'(ovf),     32'd0);
    endtask

    task automatic do_reset(input int n);
        @(negedge Clk);
        Rst = 1'b1;
        req = '0;
        repeat (n) @(posedge Clk);
        #1;
        chk_reset_vals("rst");
        @(negedge Clk);
        Rst = 1'b0;
    endtask

    // One op: present r, expect requester id granted at the next edge, then
    // consume the BUSY edge. drop clears req[id] in the grant cycle.
    task automatic op(input logic [3:0] r, input int id, input logic drop);
        logic [3:0] oh;
        exp_t       e;
        oh = 4'b0001 << id;
        @(negedge Clk);
        req = r;
        @(posedge Clk);
        #1;
        chk("grant", 32'(grant), 32'(oh));
        chk("sinc_a", sinc_a, op_arr[id]);
        e.id  = 2'(id);
        e.res = op_arr[id] + 32'd1;
        e.ovf = (op_arr[id] == 32'h7FFF_FFFF);
        sb.push_back(e);
        @(negedge Clk);
        if (drop) req = r & ~oh;
        @(posedge Clk);
        #1;
        chk("grant_busy", 32'(grant), 32'd0);
    endtask

    initial begin
        foreach (op_arr[i]) op_arr[i] = '0;

        // 1: basic op after reset
        do_reset(2);
        op_arr[0] = 32'd5;
        op(4'b0001, 0, 1'b1);
        chk("t1_result", result, 32'd6);

        // 2: all requesting continuously, rotation 0,1,2,3,0
        do_reset(2);
        for (int i = 0; i < N; i++) op_arr[i] = 32'(10 * i);
        op(4'b1111, 0, 1'b0);
        op(4'b1111, 1, 1'b0);
        op(4'b1111, 2, 1'b0);
        op(4'b1111, 3, 1'b0);
        op(4'b1111, 0, 1'b0);
        chk("t2_result", result, 32'd1);

        // 3: overflow and -1 wrap
        op_arr[2] = 32'h7FFF_FFFF;
        op_arr[1] = 32'hFFFF_FFFF;
        op(4'b0100, 2, 1'b1);
        chk("t3_wrap_res", result, 32'h8000_0000);
        chk("t3_wrap_ovf", 32'(ovf), 32'd1);
        op(4'b0010, 1, 1'b1);
        chk("t3_m1_res", result, 32'd0);
        chk("t3_m1_ovf", 32'(ovf), 32'd0);

        // 4: last_win=0 with req 0101 -> 2 first, then 0 with -8
        op_arr[0] = 32'd3;
        op(4'b0001, 0, 1'b1);
        op_arr[0] = 32'hFFFF_FFF8;
        op(4'b0101, 2, 1'b1);
        op(4'b0001, 0, 1'b1);
        chk("t4_neg_res", result, 32'hFFFF_FFF9);

        // 5: reset while BUSY drops the op and restores priority
        op_arr[3] = 32'd77;
        @(negedge Clk);
        req = 4'b1000;
        @(posedge Clk);
        #1;
        chk("t5_grant", 32'(grant), 32'b1000);
        @(negedge Clk);
        Rst = 1'b1;
        req = '0;
        @(posedge Clk);
        #1;
        chk_reset_vals("t5_busy_rst");
        @(negedge Clk);
        Rst = 1'b0;
        op(4'b1001, 0, 1'b1);
        op(4'b1000, 3, 1'b1);
        chk("t5_result", result, 32'd78);

        // 6: op_a/req changes during BUSY do not disturb the in-flight op
        op_arr[1] = 32'd100;
        @(negedge Clk);
        req = 4'b0010;
        @(posedge Clk);
        #1;
        chk("t6_grant", 32'(grant), 32'b0010);
        begin
            exp_t e;
            e.id = 2'd1; e.res = 32'd101; e.ovf = 1'b0;
            sb.push_back(e);
        end
        @(negedge Clk);
        op_arr[1] = 32'd200;
        req       = 4'b0100;
        @(posedge Clk);
        #1;
        chk("t6_inflight", result, 32'd101);
        chk("t6_busy_grant", 32'(grant), 32'd0);
        op(4'b0100, 2, 1'b1);
        op(4'b0010, 1, 1'b1);
        chk("t6_new_op", result, 32'd201);

        // idle hold: outputs keep value, no pulses
        @(negedge Clk);
        req = '0;
        repeat (3) @(posedge Clk);
        #1;
        chk("idle_result", result, 32'd201);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_grant", 32'(grant), 32'd0);
        chk("idle_id", 32'(done_id), 32'd1);

        repeat (2) @(posedge Clk);
        #2;
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
